// File: rtl/sys_defs.sv
// Shared widths and packet types for the rename stage of the out-of-order core.
package sys_defs;

    localparam int N_WAY     = 3;
    localparam int ARCH_REGS = 32;
    localparam int CDB_BITS  = 6;
    localparam int N_CKPT    = 4;
    localparam int AR_BITS   = $clog2(ARCH_REGS);
    localparam int CKPT_BITS = $clog2(N_CKPT);

    // Renamed source operand as seen by the reservation stations.
    typedef struct packed {
        logic [CDB_BITS-1:0] tag;
        logic                ready;
    } PR_PACKET;

    // Per-way information handed to the ROB at dispatch.
    typedef struct packed {
        logic [AR_BITS-1:0]  dest;
        logic [CDB_BITS-1:0] t;
        logic [CDB_BITS-1:0] told;
    } DISPATCH_ROB_PACKET;

    typedef logic [CKPT_BITS-1:0] CKPT_ID;

endpackage

// File: rtl/ckpt_alloc.sv
// Branch checkpoint slot bookkeeping: lowest-free-slot allocation, slot valid
// bits, and per-slot masks of the checkpoints taken after it (squashed together
// with it on a mispredict).
module ckpt_alloc
    import sys_defs::*;
#(
    parameter int N_SLOT = N_CKPT,
    localparam int ID_W  = $clog2(N_SLOT)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            branch_i,
    input  logic            resolve_i,
    input  logic            mispredict_i,
    input  logic [ID_W-1:0] resolve_id_i,
    output logic [ID_W-1:0] alloc_id_o,
    output logic            avail_o,
    output logic            alloc_o,
    output logic            overflow_o
);

    logic [N_SLOT-1:0]             valid_q, valid_d, kill;
    logic [N_SLOT-1:0][N_SLOT-1:0] younger_q, younger_d;
    logic                          overflow_q, overflow_d;
    logic                          req;

    // Pick the lowest free slot from registered state; a slot freed this cycle is not reusable until next cycle.
    always_comb begin
        alloc_id_o = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_id_o = ID_W'(i);
        end
        avail_o    = ~&valid_q;
        req        = branch_i && !(resolve_i && mispredict_i);
        alloc_o    = req && avail_o;
        overflow_o = overflow_q;
        overflow_d = overflow_q | (req & ~avail_o);
    end

    // Retire/squash slots and record the new slot as younger than every surviving one.
    always_comb begin
        kill = '0;
        if (resolve_i) begin
            kill[resolve_id_i] = 1'b1;
            if (mispredict_i) kill = kill | younger_q[resolve_id_i];
        end
        valid_d   = valid_q & ~kill;
        younger_d = younger_q;
        for (int s = 0; s < N_SLOT; s++) begin
            younger_d[s] = younger_q[s] & ~kill;
        end
        if (alloc_o) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (valid_d[s]) younger_d[s][alloc_id_o] = 1'b1;
            end
            valid_d[alloc_id_o]   = 1'b1;
            younger_d[alloc_id_o] = '0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            younger_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            younger_q  <= younger_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/map_table_ckpt.sv
// N-way register map table with in-group forwarding, CDB ready tracking and
// single-cycle branch checkpoint restore.
module map_table_ckpt #(
    parameter int N_WAY     = sys_defs::N_WAY,
    parameter int ARCH_REGS = sys_defs::ARCH_REGS,
    parameter int PR_BITS   = sys_defs::CDB_BITS,
    parameter int N_CKPT    = sys_defs::N_CKPT,
    localparam int AR_BITS  = $clog2(ARCH_REGS),
    localparam int CK_BITS  = $clog2(N_CKPT)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [N_WAY-1:0]                dis_valid,
    input  logic [N_WAY-1:0][AR_BITS-1:0]   dis_src1,
    input  logic [N_WAY-1:0][AR_BITS-1:0]   dis_src2,
    input  logic [N_WAY-1:0][AR_BITS-1:0]   dis_dest,
    input  logic [N_WAY-1:0]                dis_is_branch,
    input  logic [N_WAY-1:0][PR_BITS-1:0]   pr_freelist,
    input  logic [N_WAY-1:0]                cdb_valid,
    input  logic [N_WAY-1:0][PR_BITS-1:0]   cdb_tag,
    input  logic                            br_valid,
    input  logic                            br_mispredict,
    input  logic [CK_BITS-1:0]              br_ckpt_id,
    output logic [N_WAY-1:0][PR_BITS:0]     pr_packet_out1,
    output logic [N_WAY-1:0][PR_BITS:0]     pr_packet_out2,
    output logic [N_WAY-1:0][PR_BITS-1:0]   told,
    output logic [CK_BITS-1:0]              ckpt_id,
    output logic                            ckpt_avail,
    output logic                            ckpt_overflow
);

    logic [PR_BITS-1:0]   map_tag_q [ARCH_REGS];
    logic [PR_BITS-1:0]   map_tag_d [ARCH_REGS];
    logic [ARCH_REGS-1:0] map_rdy_q, map_rdy_d, map_rdy_c;
    logic [PR_BITS-1:0]   ck_tag_q  [N_CKPT][ARCH_REGS];
    logic [PR_BITS-1:0]   ck_tag_d  [N_CKPT][ARCH_REGS];
    logic [ARCH_REGS-1:0] ck_rdy_q  [N_CKPT];
    logic [ARCH_REGS-1:0] ck_rdy_d  [N_CKPT];
    logic [ARCH_REGS-1:0] ck_rdy_c  [N_CKPT];
    logic [PR_BITS-1:0]   snap_tag  [ARCH_REGS];
    logic [ARCH_REGS-1:0] snap_rdy;
    logic [AR_BITS-1:0]   lk_reg;
    logic [PR_BITS-1:0]   lk_tag;
    logic                 lk_rdy;
    logic                 mispredict, branch, alloc;

    // Tag 0 belongs to x0 and is never broadcast, so it is excluded from matching.
    function automatic logic cdb_hit(input logic [PR_BITS-1:0] t,
                                     input logic [N_WAY-1:0] v,
                                     input logic [N_WAY-1:0][PR_BITS-1:0] tags);
        cdb_hit = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (v[i] && tags[i] != '0 && tags[i] == t) cdb_hit = 1'b1;
        end
    endfunction

    assign mispredict = br_valid & br_mispredict;
    assign branch     = |(dis_valid & dis_is_branch);

    ckpt_alloc #(.N_SLOT(N_CKPT)) u_ckpt_alloc (
        .clock        (clock),
        .reset_n      (reset_n),
        .branch_i     (branch),
        .resolve_i    (br_valid),
        .mispredict_i (br_mispredict),
        .resolve_id_i (br_ckpt_id),
        .alloc_id_o   (ckpt_id),
        .avail_o      (ckpt_avail),
        .alloc_o      (alloc),
        .overflow_o   (ckpt_overflow)
    );

    // Ready bits of the live map and all snapshots with this cycle's CDB folded in.
    always_comb begin
        map_rdy_c = map_rdy_q;
        ck_rdy_c  = ck_rdy_q;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (cdb_hit(map_tag_q[r], cdb_valid, cdb_tag)) map_rdy_c[r] = 1'b1;
            for (int s = 0; s < N_CKPT; s++) begin
                if (cdb_hit(ck_tag_q[s][r], cdb_valid, cdb_tag)) ck_rdy_c[s][r] = 1'b1;
            end
        end
    end

    // Rename lookup for src1, src2 and dest of every way; older ways in the group forward their new tag.
    always_comb begin
        pr_packet_out1 = '0;
        pr_packet_out2 = '0;
        told           = '0;
        lk_reg         = '0;
        lk_tag         = '0;
        lk_rdy         = 1'b0;
        for (int j = 0; j < N_WAY; j++) begin
            for (int f = 0; f < 3; f++) begin
                case (f)
                    0:       lk_reg = dis_src1[j];
                    1:       lk_reg = dis_src2[j];
                    default: lk_reg = dis_dest[j];
                endcase
                lk_tag = map_tag_q[lk_reg];
                lk_rdy = map_rdy_c[lk_reg];
                for (int k = 0; k < N_WAY; k++) begin
                    if (k < j && dis_valid[k] && dis_dest[k] == lk_reg) begin
                        lk_tag = pr_freelist[k];
                        lk_rdy = 1'b0;
                    end
                end
                if (lk_reg == '0) begin
                    lk_tag = '0;
                    lk_rdy = 1'b1;
                end
                case (f)
                    0:       pr_packet_out1[j] = {lk_tag, lk_rdy};
                    1:       pr_packet_out2[j] = {lk_tag, lk_rdy};
                    default: told[j]           = lk_tag;
                endcase
            end
        end
    end

    // Next map: restore on mispredict, else apply ways in order, snapshotting right after the branch way.
    always_comb begin
        map_tag_d = map_tag_q;
        map_rdy_d = map_rdy_c;
        snap_tag  = map_tag_q;
        snap_rdy  = map_rdy_c;
        if (mispredict) begin
            map_tag_d = ck_tag_q[br_ckpt_id];
            map_rdy_d = ck_rdy_c[br_ckpt_id];
        end else begin
            for (int k = 0; k < N_WAY; k++) begin
                if (dis_valid[k] && dis_dest[k] != '0) begin
                    map_tag_d[dis_dest[k]] = pr_freelist[k];
                    map_rdy_d[dis_dest[k]] = 1'b0;
                end
                if (dis_valid[k] && dis_is_branch[k]) begin
                    snap_tag = map_tag_d;
                    snap_rdy = map_rdy_d;
                end
            end
        end
        ck_tag_d = ck_tag_q;
        ck_rdy_d = ck_rdy_c;
        if (alloc) begin
            ck_tag_d[ckpt_id] = snap_tag;
            ck_rdy_d[ckpt_id] = snap_rdy;
        end
    end

    // Map and snapshot storage; reset restores the identity mapping with everything ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                map_tag_q[r] <= PR_BITS'(r);
            end
            map_rdy_q <= '1;
            for (int s = 0; s < N_CKPT; s++) begin
                ck_rdy_q[s] <= '0;
                for (int r = 0; r < ARCH_REGS; r++) begin
                    ck_tag_q[s][r] <= '0;
                end
            end
        end else begin
            map_tag_q <= map_tag_d;
            map_rdy_q <= map_rdy_d;
            ck_tag_q  <= ck_tag_d;
            ck_rdy_q  <= ck_rdy_d;
        end
    end

endmodule

// File: doc/map_table_ckpt.md
# map_table_ckpt

Parametrised N-way register map table for the out-of-order RISC-V core. It renames architectural sources and destinations for each dispatch group and tracks physical-register ready bits from CDB broadcasts. It also keeps up to `N_CKPT` branch checkpoints for single-cycle mispredict recovery. It sits between dispatch and the RS/ROB, and takes new tags from the free list.

## Interface
Parameters:
- `N_WAY`, 3, dispatch/CDB width
- `ARCH_REGS`, 32, architectural registers; x0 is never renamed
- `PR_BITS`, 6, physical tag width (`CDB_BITS`)
- `N_CKPT`, 4, checkpoint slots

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `dis_valid`  in  N_WAY  way k carries an instruction
- `dis_src1`, `dis_src2`, `dis_dest`  in  N_WAY×$clog2(ARCH_REGS)  architectural registers
- `dis_is_branch`  in  N_WAY  way k needs a checkpoint
- `pr_freelist`  in  N_WAY×PR_BITS  new tag for way k
- `cdb_valid`  in  N_WAY  completion broadcast valid
- `cdb_tag`  in  N_WAY×PR_BITS  completing tag
- `br_valid`  in  1  branch resolved this cycle
- `br_mispredict`  in  1  resolution was a mispredict
- `br_ckpt_id`  in  $clog2(N_CKPT)  slot of the resolved branch
- `pr_packet_out1`, `pr_packet_out2`  out  N_WAY×PR_PACKET  src1/src2 {tag, ready}
- `told`  out  N_WAY×PR_BITS  previous mapping of `dis_dest`, for the ROB
- `ckpt_id`  out  $clog2(N_CKPT)  slot given to this cycle's branch
- `ckpt_avail`  out  1  at least one slot free
- `ckpt_overflow`  out  1  sticky error; cleared only by reset

## Operation
- State: `map[ARCH_REGS]` of {tag, ready}. Per slot: `ckpt_map`, `ckpt_valid`, `younger[N_CKPT]` mask.
- Reset (async): `map[i]={i,1}`, all slots invalid, masks 0, `ckpt_overflow=0`. Outputs follow from the reset map, so `ckpt_avail=1`.
- Lookup is combinational and applies in-group forwarding. If an earlier valid way k<j writes the same nonzero source, way j gets {`pr_freelist[k]`, 0}; the youngest such k wins. Otherwise way j reads `map`.
- CDB bypass: a looked-up tag equal to any valid nonzero `cdb_tag` returns ready=1. This does not apply to tags forwarded inside the group.
- `told[j]` is the previous mapping of `dis_dest[j]`, forwarded from earlier ways in the same way as sources. When `dis_dest=0`, `told=0`.
- Update: each valid way with `dest≠0` writes {`pr_freelist`, 0}. When several ways write the same register, the youngest way wins.
- CDB sets ready on every `map` and valid `ckpt_map` entry whose tag matches. A dest write in the same cycle overrides the CDB on that entry.
- Checkpoint: at most one branch per group, guaranteed by dispatch.
  - The snapshot is the map after applying ways 0..b, where b is the branch way, plus this cycle's CDB.
  - The lowest free slot is allocated and reported combinationally on `ckpt_id`.
  - The new slot's bit is set in `younger` of every valid slot.
- A branch presented while `ckpt_avail=0` takes no snapshot and sets `ckpt_overflow`.
- Correct resolve: invalidate slot `br_ckpt_id` and clear its bit in all `younger` masks.
- Mispredict:
  - `map` ← `ckpt_map[br_ckpt_id]` with this cycle's CDB applied.
  - Invalidate that slot and every slot in its `younger` mask.
  - Dispatch in that cycle is ignored: no map write, no snapshot.
- `cdb_tag=0` and `dis_dest=0` are ignored everywhere. x0 always reads {0, 1}.

## Timing
- Lookup, `told` and `ckpt_id` are available in the same cycle as `dis_valid`. Updates are visible in the next cycle.
- Mispredict recovery takes 1 cycle. Dispatch may resume on the following edge.
- A resolve and an allocation may fall in the same cycle.
  - Allocation sees the slot freed by a correct resolve only in the next cycle.
  - On a mispredict the allocation is dropped.
- `ckpt_avail` reflects the registered state only, with no same-cycle freeing.
- Reset mid-operation clears all checkpoints immediately and restores the identity map.

## Structure
- `sys_defs` package: `N_WAY`, `CDB_BITS`, `PR_PACKET`, `DISPATCH_ROB_PACKET`, and a new `CKPT_ID` typedef.
- One sub-module, `ckpt_alloc`: free-slot priority encoder, valid bits and `younger` masks.
- The map array and its snapshots stay in the top module.

## Test plan
- Reset, then lookup src1=5, src2=0 → tags 5/0, both ready=1. `ckpt_avail=1`.
- Group {r0,r1→r2 @33}, {r2,r4→r5 @34}, {r5,r2→r8 @35} → way1 src1={33,0}, way2 src1={34,0} and src2={33,0}. `told`={2,5,8}.
- CDB 33 in the same cycle as a lookup of r2 → ready=1 that cycle. r2 reads {33,1} on every later cycle.
- Mispredict restore:
  - Dispatch way0 r3→36, way1 branch, way2 r3→38, giving `ckpt_id`=0.
  - Then CDB 36, then mispredict slot 0.
  - Next cycle r3 reads {36,1}.
- Allocation and overflow:
  - Allocate 4 branches → ids 0,1,2,3 and `ckpt_avail=0`.
  - A 5th branch → `ckpt_overflow=1`.
  - Correct resolve of id 1 → next allocation gets id 1.
  - Mispredict of id 0 → all slots free.
- Pull `reset_n` low mid-group with 2 checkpoints live → identity map and all slots free, regardless of the clock. `ckpt_overflow=0`.
